// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

    typedef enum logic [1:0] {
        StStart,
        StRun,
        StHalted
    } fetch_state_t;

    localparam logic [31:0] EBREAK  = 32'h0010_0073;
    localparam logic [31:0] PC_STEP = 32'd4;

endpackage

// File: rtl/pc_next_logic.sv
// Combinational next-PC selection: aligned redirect target or sequential PC with wrap.
module pc_next_logic
    import fetch_pkg::*;
#(
    parameter int unsigned MEM_DEPTH = 1024
) (
    input  logic [31:0] pc_i,
    input  logic        branch_taken_i,
    input  logic [31:0] branch_target_i,
    output logic [31:0] pc_next_o
);

    localparam int unsigned AddrW = $clog2(MEM_DEPTH);
    localparam logic [31:0] Depth = 32'(MEM_DEPTH);

    logic [31:0] aligned_pc;
    logic [31:0] seq_pc;

    always_comb begin
        // Word-align and fold the target into the memory window.
        aligned_pc = '0;
        aligned_pc[AddrW-1:2] = branch_target_i[AddrW-1:2];
        seq_pc = pc_i + PC_STEP;
        if (seq_pc == Depth) begin
            seq_pc = '0;
        end
        pc_next_o = branch_taken_i ? aligned_pc : seq_pc;
    end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the PC, fills the IF/ID register, handles stall/redirect and ebreak halt.
module instruction_fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned MEM_DEPTH = 1024,
    parameter logic [31:0] EBREAK    = fetch_pkg::EBREAK
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        branchTaken,
    input  logic [31:0] branchTarget,
    input  logic [31:0] instruction,
    output logic [31:0] instructionAddress,
    output logic [31:0] ifIdInstruction,
    output logic [31:0] ifIdPc,
    output logic        ifIdValid,
    output logic        halted,
    output logic [31:0] fetchCount
);

    fetch_state_t state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  instr_q, instr_d;
    logic [31:0]  ipc_q, ipc_d;
    logic         valid_q, valid_d;
    logic [31:0]  count_q, count_d;
    logic [31:0]  pc_next;

    pc_next_logic #(
        .MEM_DEPTH(MEM_DEPTH)
    ) u_pc_next (
        .pc_i           (pc_q),
        .branch_taken_i (branchTaken),
        .branch_target_i(branchTarget),
        .pc_next_o      (pc_next)
    );

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        ipc_d   = ipc_q;
        valid_d = valid_q;
        count_d = count_q;
        unique case (state_q)
            StStart: begin
                state_d = StRun;
            end
            StRun: begin
                if (branchTaken) begin
                    pc_d    = pc_next;
                    valid_d = 1'b0;
                end else if (!stall) begin
                    instr_d = instruction;
                    ipc_d   = pc_q;
                    valid_d = 1'b1;
                    count_d = count_q + 32'd1;
                    if (instruction == EBREAK) begin
                        state_d = StHalted;
                    end else begin
                        pc_d = pc_next;
                    end
                end
            end
            StHalted: begin
                if (branchTaken) begin
                    pc_d    = pc_next;
                    valid_d = 1'b0;
                    state_d = StRun;
                end else if (!stall) begin
                    valid_d = 1'b0;
                end
            end
            default: begin
                state_d = StStart;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StStart;
            pc_q    <= RESET_PC;
            instr_q <= '0;
            ipc_q   <= '0;
            valid_q <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            ipc_q   <= ipc_d;
            valid_q <= valid_d;
            count_q <= count_d;
        end
    end

    assign instructionAddress = pc_q;
    assign ifIdInstruction    = instr_q;
    assign ifIdPc             = ipc_q;
    assign ifIdValid          = valid_q;
    assign halted             = (state_q == StHalted);
    assign fetchCount         = count_q;

endmodule

// File: doc/instruction_fetch_unit.md
# instruction_fetch_unit

Front-end fetch stage of the RISC-V pipeline: owns the program counter, drives the address into the combinational instruction memory, and registers the returned instruction with its PC into the IF/ID pipeline register. It handles stalls from hazard detection, redirects from branch/jump resolution, and halts on `ebreak`. It also keeps a count of delivered instructions for the testbench and performance counters.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_0000: PC value loaded on reset; must be a multiple of 4.
- `MEM_DEPTH`, 1024: instruction memory locations; power of two, multiple of 4.
- `EBREAK`, 32'h0010_0073: encoding that halts fetch.

Ports. One clock; reset is asynchronous and active-high.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-high reset.
- `stall`  in  1  hold the PC and IF/ID contents this cycle.
- `branchTaken`  in  1  redirect request from execute.
- `branchTarget`  in  32  redirect address.
- `instruction`  in  32  combinational read data from the instruction memory.
- `instructionAddress`  out  32  current PC, fed to the instruction memory.
- `ifIdInstruction`  out  32  registered instruction.
- `ifIdPc`  out  32  PC of `ifIdInstruction`.
- `ifIdValid`  out  1  IF/ID holds a real instruction, not a bubble.
- `halted`  out  1  fetch is frozen after `ebreak`.
- `fetchCount`  out  32  number of valid instructions delivered into IF/ID.

## Operation
- FSM states are START, RUN and HALTED. Reset forces START.
- Reset values:
  - `pc = RESET_PC`, so `instructionAddress = RESET_PC`.
  - `ifIdInstruction = 0`, `ifIdPc = 0`, `ifIdValid = 0`.
  - `halted = 0`, `fetchCount = 0`.
- START lasts one cycle and ignores all inputs. It then moves to RUN with the PC unchanged.
- RUN applies the following, in priority order, at each rising edge:
  1. **Branch:** if `branchTaken`, then `pc <= align(branchTarget)`, `ifIdValid <= 0` (flush), and the state stays RUN. A branch overrides a simultaneous stall.
  2. **Stall:** else if `stall`, the PC, all IF/ID fields and `fetchCount` hold.
  3. **Normal fetch:** otherwise:
     - `ifIdInstruction <= instruction`, `ifIdPc <= pc`, `ifIdValid <= 1`, `fetchCount <= fetchCount + 1`.
     - If `instruction == EBREAK`, the PC holds and the state moves to HALTED.
     - Otherwise `pc <= next(pc)`.
- HALTED:
  - `halted = 1`.
  - If `branchTaken`: `pc <= align(branchTarget)`, `ifIdValid <= 0`, and the state moves to RUN.
  - Else if `stall`: IF/ID holds.
  - Otherwise: `ifIdValid <= 0`; the PC and `fetchCount` hold.
- Arithmetic:
  - `align(a) = {a[31:2], 2'b00} mod MEM_DEPTH`, implemented as truncation to `$clog2(MEM_DEPTH)` bits with the upper bits zero.
  - `next(pc) = (pc + 4 == MEM_DEPTH) ? 0 : pc + 4`, so the PC wraps from `MEM_DEPTH-4` to 0.
  - `fetchCount` wraps modulo 2^32.
- Reset mid-operation returns the block to START within the same cycle, since reset is asynchronous. In-flight IF/ID contents are discarded.

## Timing
- `instructionAddress` is the PC register output, with no combinational path from any input.
- Fetch latency:
  - The instruction at PC p appears on `ifIdInstruction` one edge after p is presented, provided there is no stall or branch.
  - The first valid IF/ID arrives 2 edges after reset deasserts: the START edge, then the fetch edge.
- Redirect penalty:
  - `branchTaken` sampled at edge N gives a bubble on `ifIdValid` after N.
  - The target instruction becomes valid after edge N+1.
- `stall` is sampled at the edge and has no effect on outputs until after that edge.
- `halted` is registered and asserts in the cycle after the `ebreak` is captured into IF/ID.

## Structure
- Shared package `fetch_pkg` holds:
  - the state typedef `fetch_state_t` with START, RUN and HALTED;
  - the `EBREAK` constant;
  - the `PC_STEP = 4` constant.
- One sub-module, `pc_next_logic`, is combinational. It computes `align` and `next` from `pc`, `branchTaken`, `branchTarget` and `MEM_DEPTH`.
- The FSM, the PC register, the IF/ID register and the counter live in the top module.

## Test plan
- **Reset and sequential fetch:** release reset with the memory model returning word = address.
  - `ifIdValid` first rises after edge 2, with `ifIdPc` = 0, 4, 8, 12 on consecutive cycles.
  - `fetchCount` = 4 after four fetches.
- **Stall:** assert `stall` for 3 cycles while PC = 8.
  - `instructionAddress` stays 8, IF/ID holds PC 4, and `fetchCount` holds.
  - After release, `ifIdPc` = 8.
- **Branch with simultaneous stall:** at PC = 12, assert `branchTaken` with target 32'h0000_0107 and `stall` = 1.
  - Next cycle: `instructionAddress` = 0x104 and `ifIdValid` = 0.
  - The following cycle: `ifIdPc` = 0x104.
- **Wrap-around:** branch to 1016.
  - Observed addresses are 1016, 1020, 0, 4.
  - A target of 32'h0000_1008 aligns to 8.
- **Ebreak halt and restart:** the memory returns 32'h0010_0073 at PC 20.
  - IF/ID captures it with valid = 1; `halted` = 1 from the next cycle.
  - `ifIdValid` = 0 thereafter and the PC stays 20.
  - `branchTaken` to 0 clears `halted` and fetch resumes from 0.
- **Reset mid-operation:** pulse `reset` asynchronously (not edge-aligned) during the HALTED state.
  - Immediately: `instructionAddress` = `RESET_PC`, `ifIdValid` = 0, `halted` = 0, `fetchCount` = 0.
